// File: rtl/dvp_tx_frame_gen.sv
// ---------------------------------------------------------------------------
// dvp_tx_frame_gen
//   Generates a DVP (camera-style parallel) transmit frame from a stream of
//   half-pixel bytes. A frame is VSYNC pulse, vertical back porch, then
//   img_height rows of 2*img_width bytes with an inter-row blank between rows.
//   Underflow or a misplaced end-of-frame marker raises a trap and, where data
//   remains upstream, drains it up to the next end-of-frame marker.
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   s_hpxl_*       byte stream from DMA (dat/last/vld in, rdy out)
//   tx_en          transmit enable, sampled only while idle
//   tx_start       queued start request level; tx_start_qed pops it
//   img_width      pixels per row (>=1), img_height rows per frame (>=1)
//   tx_state       current FSM state
//   dvp_vsync, dvp_href, dvp_data   registered DVP outputs
//   irq            frame-complete pulse, trap underflow/misalignment pulse
// ---------------------------------------------------------------------------
module dvp_tx_frame_gen #(
  parameter int DVP_DATA_W  = 8,
  parameter int IMG_DIM_MAX = 640,
  parameter int IMG_DIM_W   = $clog2(IMG_DIM_MAX),
  parameter int VSYNC_CYC   = 16,
  parameter int VBP_CYC     = 32,
  parameter int HBLANK_CYC  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DVP_DATA_W-1:0] s_hpxl_dat,
  input  logic                  s_hpxl_last,
  input  logic                  s_hpxl_vld,
  output logic                  s_hpxl_rdy,
  input  logic                  tx_en,
  input  logic                  tx_start,
  output logic                  tx_start_qed,
  input  logic [IMG_DIM_W-1:0]  img_width,
  input  logic [IMG_DIM_W-1:0]  img_height,
  output logic [2:0]            tx_state,
  output logic                  dvp_vsync,
  output logic                  dvp_href,
  output logic [DVP_DATA_W-1:0] dvp_data,
  output logic                  irq,
  output logic                  trap
);

  // One shared blank counter serves VSYNC, VBP and HBLANK; size it for the
  // longest of the three.
  localparam int BLANK_MAX_01 = (VSYNC_CYC > VBP_CYC) ? VSYNC_CYC : VBP_CYC;
  localparam int BLANK_MAX    = (BLANK_MAX_01 > HBLANK_CYC) ? BLANK_MAX_01 : HBLANK_CYC;
  localparam int BLANK_W      = (BLANK_MAX > 1) ? $clog2(BLANK_MAX) : 1;

  localparam logic [BLANK_W-1:0] VSYNC_LAST  = BLANK_W'(VSYNC_CYC - 1);
  localparam logic [BLANK_W-1:0] VBP_LAST    = BLANK_W'(VBP_CYC - 1);
  localparam logic [BLANK_W-1:0] HBLANK_LAST = BLANK_W'(HBLANK_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_HBLANK = 3'd4,
    ST_DRAIN  = 3'd5
  } state_e;

  state_e                 state_q,  state_d;
  logic [BLANK_W-1:0]     blank_q,  blank_d;
  logic                   tgl_q,    tgl_d;
  logic [IMG_DIM_W-1:0]   w_cnt_q,  w_cnt_d;
  logic [IMG_DIM_W-1:0]   h_cnt_q,  h_cnt_d;
  logic                   vsync_q,  vsync_d;
  logic                   href_q,   href_d;
  logic [DVP_DATA_W-1:0]  data_q,   data_d;
  logic                   irq_q,    irq_d;
  logic                   trap_q,   trap_d;

  logic [IMG_DIM_W-1:0]   w_lim;
  logic [IMG_DIM_W-1:0]   h_lim;
  logic                   row_end;
  logic                   frame_end;
  logic                   start_pop;

  assign w_lim     = img_width  - IMG_DIM_W'(1);
  assign h_lim     = img_height - IMG_DIM_W'(1);
  assign row_end   = tgl_q & (w_cnt_q == w_lim);
  assign frame_end = row_end & (h_cnt_q == h_lim);
  assign start_pop = (state_q == ST_IDLE) & tx_en & tx_start;

  always_comb begin
    state_d = state_q;
    blank_d = blank_q;
    tgl_d   = tgl_q;
    w_cnt_d = w_cnt_q;
    h_cnt_d = h_cnt_q;
    vsync_d = 1'b0;
    href_d  = 1'b0;
    data_d  = '0;
    irq_d   = 1'b0;
    trap_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_pop) begin
          state_d = ST_VSYNC;
          blank_d = '0;
        end
      end

      ST_VSYNC: begin
        vsync_d = 1'b1;
        if (blank_q == VSYNC_LAST) begin
          state_d = ST_VBP;
          blank_d = '0;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end

      ST_VBP: begin
        if (blank_q == VBP_LAST) begin
          state_d = ST_ACTIVE;
          blank_d = '0;
          tgl_d   = 1'b0;
          w_cnt_d = '0;
          h_cnt_d = '0;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end

      ST_ACTIVE: begin
        href_d = 1'b1;
        if (!s_hpxl_vld) begin
          // Underflow: keep href up with a zero byte so the row length seen
          // downstream stays intact for this cycle, then drain.
          trap_d  = 1'b1;
          state_d = ST_DRAIN;
        end else begin
          data_d = s_hpxl_dat;
          if (s_hpxl_last != frame_end) begin
            // An early last means upstream has nothing left to drain.
            trap_d  = 1'b1;
            state_d = s_hpxl_last ? ST_IDLE : ST_DRAIN;
          end else if (frame_end) begin
            irq_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (row_end) begin
            h_cnt_d = h_cnt_q + 1'b1;
            w_cnt_d = '0;
            tgl_d   = 1'b0;
            blank_d = '0;
            state_d = ST_HBLANK;
          end else begin
            tgl_d = ~tgl_q;
            if (tgl_q) begin
              w_cnt_d = w_cnt_q + 1'b1;
            end
          end
        end
      end

      ST_HBLANK: begin
        if (blank_q == HBLANK_LAST) begin
          state_d = ST_ACTIVE;
          blank_d = '0;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end

      ST_DRAIN: begin
        if (s_hpxl_vld && s_hpxl_last) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      blank_q <= '0;
      tgl_q   <= 1'b0;
      w_cnt_q <= '0;
      h_cnt_q <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= '0;
      irq_q   <= 1'b0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      blank_q <= blank_d;
      tgl_q   <= tgl_d;
      w_cnt_q <= w_cnt_d;
      h_cnt_q <= h_cnt_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      data_q  <= data_d;
      irq_q   <= irq_d;
      trap_q  <= trap_d;
    end
  end

  assign s_hpxl_rdy   = (state_q == ST_ACTIVE) | (state_q == ST_DRAIN);
  assign tx_start_qed = start_pop;
  assign tx_state     = state_q;
  assign dvp_vsync    = vsync_q;
  assign dvp_href     = href_q;
  assign dvp_data     = data_q;
  assign irq          = irq_q;
  assign trap         = trap_q;

endmodule

// File: tb/tb_dvp_tx_frame_gen.sv
// ---------------------------------------------------------------------------
// tb_dvp_tx_frame_gen
//   Randomized frames (size, data, fault type/position) checked cycle by
//   cycle against an expected timeline computed from the frame rules.
// ---------------------------------------------------------------------------
module tb_dvp_tx_frame_gen;

  localparam int DW  = 8;
  localparam int IW  = 10;
  localparam int V   = 2;
  localparam int B   = 3;
  localparam int HB  = 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VSYNC  = 3'd1;
  localparam logic [2:0] S_VBP    = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_HBLANK = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_hpxl_dat = '0;
  logic          s_hpxl_last = 1'b0;
  logic          s_hpxl_vld = 1'b0;
  logic          s_hpxl_rdy;
  logic          tx_en = 1'b0;
  logic          tx_start = 1'b0;
  logic          tx_start_qed;
  logic [IW-1:0] img_width = IW'(2);
  logic [IW-1:0] img_height = IW'(2);
  logic [2:0]    tx_state;
  logic          dvp_vsync;
  logic          dvp_href;
  logic [DW-1:0] dvp_data;
  logic          irq;
  logic          trap;

  dvp_tx_frame_gen #(
    .DVP_DATA_W (DW),
    .IMG_DIM_MAX(640),
    .IMG_DIM_W  (IW),
    .VSYNC_CYC  (V),
    .VBP_CYC    (B),
    .HBLANK_CYC (HB)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_hpxl_dat  (s_hpxl_dat),
    .s_hpxl_last (s_hpxl_last),
    .s_hpxl_vld  (s_hpxl_vld),
    .s_hpxl_rdy  (s_hpxl_rdy),
    .tx_en       (tx_en),
    .tx_start    (tx_start),
    .tx_start_qed(tx_start_qed),
    .img_width   (img_width),
    .img_height  (img_height),
    .tx_state    (tx_state),
    .dvp_vsync   (dvp_vsync),
    .dvp_href    (dvp_href),
    .dvp_data    (dvp_data),
    .irq         (irq),
    .trap        (trap)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected per-cycle record: state during a cycle and the outputs that
  // cycle produces (visible one cycle later).
  typedef struct packed {
    logic [2:0] st;
    logic       vs;
    logic       hr;
    logic [7:0] dt;
    logic       irq;
    logic       trap;
  } ent_t;

  ent_t       exp_q[$];
  logic [7:0] sb[$];

  function automatic ent_t mk(logic [2:0] st, logic vs, logic hr, logic [7:0] dt,
                              logic i, logic t);
    ent_t e;
    e.st = st; e.vs = vs; e.hr = hr; e.dt = dt; e.irq = i; e.trap = t;
    return e;
  endfunction

  // fault: 0 none, 1 vld hole at byte fp, 2 early last on byte fp,
  //        3 last missing on final byte, arriving extra bytes later.
  task automatic build(input int w, input int h, input int fault, input int fp,
                       input int extra, input bit seq);
    int total, len;
    bit done;
    exp_q.delete();
    sb.delete();
    total = 2 * w * h;
    len = (fault == 2) ? fp + 1 : (fault == 3) ? total + extra : total;
    for (int i = 0; i < len; i++)
      sb.push_back(seq ? 8'(i + 1) : 8'($urandom_range(1, 255)));
    exp_q.push_back(mk(S_IDLE, 0, 0, 8'h00, 0, 0));
    repeat (V) exp_q.push_back(mk(S_VSYNC, 1, 0, 8'h00, 0, 0));
    repeat (B) exp_q.push_back(mk(S_VBP, 0, 0, 8'h00, 0, 0));
    done = 0;
    for (int r = 0; r < h && !done; r++) begin
      for (int i = 0; i < 2 * w && !done; i++) begin
        int b;
        b = r * 2 * w + i;
        if (fault == 1 && b == fp) begin
          exp_q.push_back(mk(S_ACTIVE, 0, 1, 8'h00, 0, 1));
          for (int k = fp; k < total; k++) exp_q.push_back(mk(S_DRAIN, 0, 0, 8'h00, 0, 0));
          done = 1;
        end else if (fault == 2 && b == fp) begin
          exp_q.push_back(mk(S_ACTIVE, 0, 1, sb[b], 0, 1));
          done = 1;
        end else if (b == total - 1) begin
          if (fault == 3) begin
            exp_q.push_back(mk(S_ACTIVE, 0, 1, sb[b], 0, 1));
            for (int k = total; k < len; k++) exp_q.push_back(mk(S_DRAIN, 0, 0, 8'h00, 0, 0));
          end else begin
            exp_q.push_back(mk(S_ACTIVE, 0, 1, sb[b], 1, 0));
          end
          done = 1;
        end else begin
          exp_q.push_back(mk(S_ACTIVE, 0, 1, sb[b], 0, 0));
        end
      end
      if (!done && r < h - 1)
        repeat (HB) exp_q.push_back(mk(S_HBLANK, 0, 0, 8'h00, 0, 0));
    end
  endtask

  // Entered at a negedge in IDLE with tx_en/tx_start already driven; returns
  // at the negedge (+1) of the IDLE cycle after the frame.
  task automatic run_frame(input int w, input int h, input int fault, input int fp,
                           input int extra, input bit seq, input bit drop_en,
                           input bit next_start);
    int   lc, bi, len;
    bit   hole_done, acc;
    ent_t e;
    img_width  = IW'(w);
    img_height = IW'(h);
    build(w, h, fault, fp, extra, seq);
    len = sb.size();
    lc  = exp_q.size() - 1;
    bi = 0;
    hole_done = 0;
    s_hpxl_vld = 1'b0;
    #1;
    check("start_state", tx_state, S_IDLE);
    check("start_qed", tx_start_qed, 1);
    @(negedge clk);
    for (int m = 1; m <= lc + 1; m++) begin
      e = exp_q[m-1];
      check("vsync", dvp_vsync, e.vs);
      check("href", dvp_href, e.hr);
      check("data", dvp_data, e.dt);
      check("irq", irq, e.irq);
      check("trap", trap, e.trap);
      if (m <= lc) begin
        if (drop_en && m == 3) tx_en = 1'b0;
        check("state", tx_state, exp_q[m].st);
        check("rdy", s_hpxl_rdy, (exp_q[m].st == S_ACTIVE) || (exp_q[m].st == S_DRAIN));
        if (bi < len) begin
          s_hpxl_dat  = sb[bi];
          s_hpxl_last = (bi == len - 1);
          s_hpxl_vld  = !(fault == 1 && bi == fp && !hole_done);
        end else begin
          s_hpxl_dat = '0; s_hpxl_last = 1'b0; s_hpxl_vld = 1'b0;
        end
        #1;
        check("qed_busy", tx_start_qed, 0);
        acc = s_hpxl_rdy && s_hpxl_vld;
        if (fault == 1 && s_hpxl_rdy && !s_hpxl_vld) hole_done = 1;
        @(posedge clk);
        if (acc) bi++;
        @(negedge clk);
      end else begin
        s_hpxl_vld = 1'b0; s_hpxl_last = 1'b0; s_hpxl_dat = '0;
        tx_start = next_start;
        #1;
        check("end_state", tx_state, S_IDLE);
        check("end_rdy", s_hpxl_rdy, 0);
        check("end_qed", tx_start_qed, tx_en && next_start);
        check("bytes_used", bi, len);
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      check("idle_state", tx_state, S_IDLE);
      check("idle_href", dvp_href, 0);
      check("idle_vsync", dvp_vsync, 0);
      check("idle_rdy", s_hpxl_rdy, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int w, h, f, fp, ex, ns, total;

    repeat (2) @(negedge clk);
    #1;
    check("rst_state", tx_state, S_IDLE);
    check("rst_vsync", dvp_vsync, 0);
    check("rst_href", dvp_href, 0);
    check("rst_data", dvp_data, 0);
    check("rst_irq", irq, 0);
    check("rst_trap", trap, 0);
    check("rst_rdy", s_hpxl_rdy, 0);
    check("rst_qed", tx_start_qed, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tx_en = 1'b1;
    idle_cycles(3);
    tx_en = 1'b0; tx_start = 1'b1;
    idle_cycles(2);
    check("qed_no_en", tx_start_qed, 0);

    // Nominal 2x2 frame, bytes 1..8
    tx_en = 1'b1;
    run_frame(2, 2, 0, 0, 0, 1, 0, 0);
    idle_cycles(2);
    // Underflow on 3rd byte
    tx_start = 1'b1;
    run_frame(2, 2, 1, 2, 0, 1, 0, 0);
    idle_cycles(1);
    // Early last on byte 4
    tx_start = 1'b1;
    run_frame(2, 2, 2, 3, 0, 1, 0, 0);
    idle_cycles(1);
    // Late last: two extra bytes before the marker
    tx_start = 1'b1;
    run_frame(2, 2, 3, 0, 2, 1, 0, 0);
    idle_cycles(1);
    // Back-to-back stream with tx_start held, then tx_en dropped mid-frame
    tx_start = 1'b1;
    run_frame(2, 1, 0, 0, 0, 0, 0, 1);
    run_frame(1, 2, 0, 0, 0, 0, 0, 1);
    run_frame(3, 1, 0, 0, 0, 0, 1, 1);
    idle_cycles(2);
    tx_en = 1'b1;

    // Randomized frames
    tx_start = 1'b1;
    for (int n = 0; n < 40; n++) begin
      w = $urandom_range(1, 3);
      h = $urandom_range(1, 3);
      total = 2 * w * h;
      f = $urandom_range(0, 5);
      if (f > 3) f = 0;
      fp = (f == 1) ? $urandom_range(0, total - 1) : (f == 2) ? $urandom_range(0, total - 2) : 0;
      ex = (f == 3) ? $urandom_range(1, 3) : 0;
      ns = (n == 39) ? 0 : $urandom_range(0, 1);
      run_frame(w, h, f, fp, ex, 0, 0, ns[0]);
      if (ns == 0) begin
        idle_cycles($urandom_range(1, 3));
        tx_start = 1'b1;
      end
    end
    tx_start = 1'b0;
    idle_cycles(1);

    // Reset in the middle of ACTIVE
    img_width = IW'(3); img_height = IW'(3);
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    s_hpxl_vld = 1'b1; s_hpxl_dat = 8'h5A; s_hpxl_last = 1'b0;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (tx_state == S_ACTIVE) found = 1;
    end
    check("reach_active", found, 1);
    repeat (2) @(negedge clk);
    check("pre_rst_href", dvp_href, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", tx_state, S_IDLE);
    check("mid_rst_vsync", dvp_vsync, 0);
    check("mid_rst_href", dvp_href, 0);
    check("mid_rst_data", dvp_data, 0);
    check("mid_rst_irq", irq, 0);
    check("mid_rst_trap", trap, 0);
    check("mid_rst_rdy", s_hpxl_rdy, 0);
    check("mid_rst_qed", tx_start_qed, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    s_hpxl_vld = 1'b0;
    idle_cycles(3);
    check("post_rst_irq", irq, 0);
    check("post_rst_trap", trap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dvp_tx_frame_gen.md
DVP_TX_FRAME_GEN -- requirements
Module: dvp_tx_frame_gen

Interface
REQ-001 SHALL provide parameters: DVP_DATA_W, default 8, DVP byte width; IMG_DIM_MAX, default 640, maximum image dimension; IMG_DIM_W, default $clog2(IMG_DIM_MAX), dimension width; VSYNC_CYC, default 16, VSYNC pulse length; VBP_CYC, default 32, vertical back porch; HBLANK_CYC, default 8, inter-row blank.
REQ-002 SHALL provide ports (name direction width meaning):
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- s_hpxl_dat  in  DVP_DATA_W  half-pixel byte from DMA
- s_hpxl_last  in  1  final byte of frame
- s_hpxl_vld  in  1  byte valid
- s_hpxl_rdy  out  1  byte accepted
- tx_en  in  1  TX enable
- tx_start  in  1  start request (queued level)
- tx_start_qed  out  1  1-cycle pop of start request
- img_width  in  IMG_DIM_W  pixels per row (>=1)
- img_height  in  IMG_DIM_W  rows per frame (>=1)
- tx_state  out  3  current state
- dvp_vsync  out  1  frame sync
- dvp_href  out  1  row data valid
- dvp_data  out  DVP_DATA_W  pixel byte
- irq  out  1  frame-complete pulse
- trap  out  1  underflow/misalignment pulse

Function
REQ-003 SHALL use states IDLE=0, VSYNC=1, VBP=2, ACTIVE=3, HBLANK=4, DRAIN=5; tx_state equals the registered state.
REQ-004 SHALL register dvp_vsync, dvp_href, dvp_data, irq and trap; each reflects the state/event of the previous cycle (1-cycle latency).
REQ-005 IDLE: s_hpxl_rdy=0; on tx_en & tx_start go to VSYNC, pulse tx_start_qed for 1 cycle, clear blank counter; otherwise stay.
REQ-006 VSYNC: dvp_vsync driven 1; blank counter counts 0..VSYNC_CYC-1, then go to VBP with counter cleared.
REQ-007 VBP: all outputs low; after VBP_CYC cycles go to ACTIVE with byte toggle, w_cnt and h_cnt cleared.
REQ-008 ACTIVE: s_hpxl_rdy=1; dvp_href=1; each cycle consumes exactly one byte; byte toggle flips per byte; w_cnt increments when toggle=1 (second byte of pixel).
REQ-009 Row end = toggle=1 & w_cnt==img_width-1: if h_cnt==img_height-1 go to IDLE and pulse irq; else h_cnt+1, w_cnt=0, go to HBLANK.
REQ-010 HBLANK: s_hpxl_rdy=0, href low; after HBLANK_CYC cycles return to ACTIVE.
REQ-011 Underflow: s_hpxl_vld=0 in ACTIVE -> dvp_data=0 for that cycle, href still 1, trap pulse, go to DRAIN.
REQ-012 Misalignment: s_hpxl_last value differs from (final byte of final row) on an accepted byte -> byte is still output, trap pulse, go to DRAIN; if it was an early last, go to IDLE instead (frame data exhausted).
REQ-013 DRAIN: s_hpxl_rdy=1, outputs low; discard bytes until accepted byte with s_hpxl_last=1, then go to IDLE without irq.
REQ-014 tx_en is sampled only in IDLE; deassertion mid-frame completes the current frame.
REQ-015 img_width/img_height are assumed stable from VSYNC entry to frame end; counters compare with the ==limit-1 rule at IMG_DIM_W width.
REQ-016 dvp_data SHALL be 0 whenever dvp_href is 0.

Reset
REQ-017 On rst_n low: state=IDLE; all counters, toggle, dvp_vsync, dvp_href, dvp_data, irq and trap = 0; s_hpxl_rdy=0 and tx_start_qed=0.
REQ-018 Reset mid-frame SHALL abort immediately with no irq/trap; after release the block waits in IDLE for a new tx_start.

Verification
REQ-019 Nominal (VSYNC_CYC=2, VBP_CYC=3, HBLANK_CYC=2, width=2, height=2), 8 bytes 0x01..0x08, last on 0x08 -> vsync high 2 cycles, href high 4 cycles (0x01..0x04), low 2, high 4 (0x05..0x08), one irq, return to IDLE.
REQ-020 Underflow: vld dropped on 3rd byte -> dvp_data=0 that cycle, trap pulse once, DRAIN discards until last, no irq.
REQ-021 Early last on byte 4 of 8 -> trap, IDLE next cycle, no irq; late last (absent on byte 8) -> trap, DRAIN until last seen.
REQ-022 Stream: tx_start held high, tx_en=1 -> back-to-back frames, tx_start_qed pulse per frame; tx_en dropped mid-frame -> frame completes with irq, then IDLE.
REQ-023 rst_n asserted during ACTIVE -> all outputs 0 in the same cycle, IDLE after release.
